data_mem_io: RTL and testbench
==============================

// Module: data_mem_io
// PURPOSE
//  Data-side memory stage driven by the sequential proc core (dataAddr/dataOut/writeEnable in, dataIn out).
//  Holds the data RAM plus a small memory-mapped I/O page: a TX FIFO draining to a host via valid/ready,
//  a status register and a snapshot cycle counter. Replaces the bench-level flat data array.
// PARAMETERS
//  RAM_WORDS  240  RAM depth; occupies addresses 0x00..RAM_WORDS-1 (must be <= 0xF0)
//  TX_DEPTH   4    TX FIFO entries; power of 2, >= 2
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  reset        in   1   synchronous, active-high reset
//  dataAddr     in   8   TypeDataAddr from core
//  dataOut      in   8   TypeDataWord write data from core
//  writeEnable  in   1   write strobe from core, single cycle
//  dataIn       out  8   TypeDataWord read data to core, combinational from dataAddr
//  tx_data      out  8   FIFO head byte to host
//  tx_valid     out  1   FIFO non-empty
//  tx_ready     in   1   host accepts head when tx_valid && tx_ready at posedge
// BEHAVIOUR
//  Timing: one clock (clk), synchronous active-high reset. Core drives addr/data/we at the EX edge
//  and samples dataIn at the MEM edge, so reads are zero-latency combinational. A write commits
//  at the posedge where writeEnable=1. Reads have no side effects.
//  Map: 0x00..RAM_WORDS-1 RAM | 0xF0 TXDATA | 0xF1 STATUS | 0xF4 CNT_LO | 0xF5 CNT_HI | all other: read 0x00, write ignored.
//  TXDATA (0xF0)
//   - write: push dataOut.
//   - read: 0x00.
//  STATUS (0xF1), read = {4'b0, ovf, 1'b0, empty, full}
//   - write with bit3=1 clears ovf; other write bits are ignored.
//  FIFO rules
//   - Push while full: data dropped, ovf sticky set. Applies even if a pop happens in the same cycle.
//   - Push + pop same cycle, not full: both occur and count is unchanged.
//   - Push into empty FIFO: tx_valid=1 from the next cycle.
//   - tx_data stable while tx_valid && !tx_ready.
//   - Pointers wrap modulo TX_DEPTH; count width is clog2(TX_DEPTH)+1.
//  CNT (0xF4/0xF5), see CONFIGURATION
//   - Any write to 0xF4 snapshots the 16-bit free-running counter into the latch.
//   - Reads of 0xF4 and 0xF5 return the latch low and high bytes.
//   - Counter wraps 0xFFFF -> 0x0000.
//  Reset values
//   - tx_valid=0; FIFO empty (pointers and count 0); ovf=0; counter=0; latch=0.
//   - STATUS reads 0x02. tx_data is don't-care while tx_valid=0.
//   - RAM contents are not cleared.
//   - Reset mid-transfer discards FIFO contents. A write coincident with reset is lost.
// CONFIGURATION
//  DMEM_CYCLE_CNT_EN defined: counter and latch are present as described above.
//  DMEM_CYCLE_CNT_EN undefined: no counter logic; 0xF4/0xF5 read 0x00 and writes are ignored.
// STRUCTURE
//  proc_package additions:
//   - c_MMIO_TXDATA, c_MMIO_STATUS, c_MMIO_CNT_LO, c_MMIO_CNT_HI (TypeDataAddr constants)
//   - c_STAT_FULL_BIT, c_STAT_EMPTY_BIT, c_STAT_OVF_BIT
//   - reuse TypeDataWord and TypeDataAddr
//  Sub-module tx_fifo (params WIDTH, DEPTH; push/pop/full/empty/head). Top holds decode, RAM, status, counter.
// TESTING
//  1. Reset; read 0xF1 -> 0x02; tx_valid=0; read 0xF0 -> 0x00.
//  2. Write 0x5A to 0x10, then addr=0x10 -> dataIn=0x5A same cycle; write 0x5A to 0xF0 -> RAM[0x10] unchanged.
//  3. tx_ready=0, push 0x01..0x04 -> STATUS 0x01; push 0x05 -> STATUS 0x09.
//     tx_ready=1 -> host sees 0x01..0x04 in order, then tx_valid=0.
//  4. FIFO holds 2 entries; push 0x77 with tx_ready=1 same cycle -> count stays 2, 0x77 drained last.
//     Full FIFO, push + pop same cycle -> push dropped, ovf=1; write 0x08 to 0xF1 -> ovf=0.
//  5. DMEM_CYCLE_CNT_EN: reset, write 0xF4 at cycle k -> 0xF4/0xF5 read k[7:0]/k[15:8], unchanged 10 cycles later.
//     Without the macro -> both read 0x00.
//  6. Three pushes, then reset mid-drain -> tx_valid=0 next cycle; STATUS 0x02; unmapped 0xF8 read 0x00, write no effect.

Source files
------------

// File: rtl/data_mem_io_pkg.sv
`default_nettype none
// ============================================================================
// Module : data_mem_io_pkg
// Brief  : Shared types and memory-map constants for the data-side memory stage.
// Rev    : 1.0  initial release
// ============================================================================
package data_mem_io_pkg;

  typedef logic [7:0] TypeDataWord;
  typedef logic [7:0] TypeDataAddr;

  localparam TypeDataAddr c_MMIO_TXDATA = 8'hF0;
  localparam TypeDataAddr c_MMIO_STATUS = 8'hF1;
  localparam TypeDataAddr c_MMIO_CNT_LO = 8'hF4;
  localparam TypeDataAddr c_MMIO_CNT_HI = 8'hF5;

  localparam int c_STAT_FULL_BIT  = 0;
  localparam int c_STAT_EMPTY_BIT = 1;
  localparam int c_STAT_OVF_BIT   = 3;

  localparam int c_CNT_WIDTH = 16;

endpackage
`default_nettype wire

// File: rtl/data_mem_io_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module : tx_fifo
// Brief  : Circular TX FIFO; pushes while full are dropped by the FIFO itself.
// Rev    : 1.0  initial release
// ============================================================================
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0] c_FULL_COUNT = (c_PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wrPtr;
  logic [c_PTR_W-1:0] r_rdPtr;
  logic [c_PTR_W:0]   r_count;

  logic w_doPush;
  logic w_doPop;

  assign full     = (r_count == c_FULL_COUNT);
  assign empty    = (r_count == '0);
  assign head     = r_mem[r_rdPtr];
  // Full-ness is judged before the pop, so a same-cycle pop never frees room.
  assign w_doPush = push && !full;
  assign w_doPop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_doPush && !w_doPop) begin
        r_count <= r_count + 1'b1;
      end else if (w_doPop && !w_doPush) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_io.sv
`default_nettype none
// ============================================================================
// Module : data_mem_io
// Brief  : Data RAM plus MMIO page (TX FIFO, status, optional cycle counter).
//          Cycle counter is built only when DMEM_CYCLE_CNT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module data_mem_io
  import data_mem_io_pkg::*;
#(
  parameter int RAM_WORDS = 240,
  parameter int TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  TypeDataAddr dataAddr,
  input  TypeDataWord dataOut,
  input  logic        writeEnable,
  output TypeDataWord dataIn,
  output TypeDataWord tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  TypeDataWord r_ram [RAM_WORDS];
  logic        r_ovf;

  logic        w_ramHit;
  logic        w_pushReq;
  logic        w_full;
  logic        w_empty;
  TypeDataWord w_status;

  assign w_ramHit  = (int'(dataAddr) < RAM_WORDS);
  assign w_pushReq = writeEnable && (dataAddr == c_MMIO_TXDATA);
  assign tx_valid  = !w_empty;

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_txFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (w_pushReq),
    .pushData (dataOut),
    .pop      (tx_valid && tx_ready),
    .full     (w_full),
    .empty    (w_empty),
    .head     (tx_data)
  );

  // RAM has no reset: contents survive a core reset.
  always_ff @(posedge clk) begin
    if (!reset && writeEnable && w_ramHit) begin
      r_ram[dataAddr] <= dataOut;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_pushReq && w_full) begin
      r_ovf <= 1'b1;
    end else if (writeEnable && (dataAddr == c_MMIO_STATUS) && dataOut[c_STAT_OVF_BIT]) begin
      r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_status                   = '0;
    w_status[c_STAT_FULL_BIT]  = w_full;
    w_status[c_STAT_EMPTY_BIT] = w_empty;
    w_status[c_STAT_OVF_BIT]   = r_ovf;
  end

`ifdef DMEM_CYCLE_CNT_EN
  logic [c_CNT_WIDTH-1:0] r_cycleCnt;
  logic [c_CNT_WIDTH-1:0] r_cntLatch;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycleCnt <= '0;
      r_cntLatch <= '0;
    end else begin
      r_cycleCnt <= r_cycleCnt + 1'b1;
      if (writeEnable && (dataAddr == c_MMIO_CNT_LO)) begin
        r_cntLatch <= r_cycleCnt;
      end
    end
  end
`endif

  always_comb begin
    dataIn = '0;
    if (w_ramHit) begin
      dataIn = r_ram[dataAddr];
    end else begin
      case (dataAddr)
        c_MMIO_STATUS: dataIn = w_status;
`ifdef DMEM_CYCLE_CNT_EN
        c_MMIO_CNT_LO: dataIn = r_cntLatch[7:0];
        c_MMIO_CNT_HI: dataIn = r_cntLatch[15:8];
`endif
        default:       dataIn = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_io.sv
`default_nettype none
// ============================================================================
// Module : tb_data_mem_io
// Brief  : Randomized and directed bench for data_mem_io against a queue model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_data_mem_io;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] dataAddr;
  logic [7:0] dataOut;
  logic       writeEnable;
  logic [7:0] dataIn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  byte unsigned m_q[$];
  bit           m_ovf;
  int unsigned  m_cnt;
  int unsigned  m_latch;
  byte unsigned m_ram [256];
  bit           m_known [256];

  always #5 clk = ~clk;

  data_mem_io u_dut (
    .clk         (clk),
    .reset       (reset),
    .dataAddr    (dataAddr),
    .dataOut     (dataOut),
    .writeEnable (writeEnable),
    .dataIn      (dataIn),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready)
  );

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit addr_known(input int a);
    return (a >= 240) || m_known[a];
  endfunction

  function automatic logic [7:0] exp_read(input int a);
    logic [7:0] v;
    v = 8'h00;
    if (a < 240) v = m_ram[a];
    else if (a == 'hF1) v = {4'b0, m_ovf, 1'b0, m_q.size() == 0, m_q.size() == 4};
`ifdef DMEM_CYCLE_CNT_EN
    else if (a == 'hF4) v = m_latch[7:0];
    else if (a == 'hF5) v = m_latch[15:8];
`endif
    return v;
  endfunction

  task automatic model_step(input int a, input byte unsigned d, input bit we,
                            input bit rdy, input bit rst);
    bit pushIt;
    pushIt = 1'b0;
    if (rst) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_cnt   = 0;
      m_latch = 0;
    end else begin
      if (we) begin
        if (a < 240) begin
          m_ram[a]   = d;
          m_known[a] = 1'b1;
        end else if (a == 'hF0) begin
          if (m_q.size() == 4) m_ovf = 1'b1;
          else pushIt = 1'b1;
        end else if (a == 'hF1) begin
          if (d[3]) m_ovf = 1'b0;
        end
`ifdef DMEM_CYCLE_CNT_EN
        else if (a == 'hF4) m_latch = m_cnt;
`endif
      end
      if (rdy && m_q.size() != 0) void'(m_q.pop_front());
      if (pushIt) m_q.push_back(d);
      m_cnt = (m_cnt + 1) % 65536;
    end
  endtask

  task automatic tick(input logic [7:0] a, input logic [7:0] d, input bit we,
                      input bit rdy, input bit rst, input bit chk);
    dataAddr    = a;
    dataOut     = d;
    writeEnable = we;
    tx_ready    = rdy;
    reset       = rst;
    #1;
    if (chk) begin
      check8("tx_valid", {7'b0, tx_valid}, {7'b0, m_q.size() != 0});
      if (m_q.size() != 0) check8("tx_data", tx_data, m_q[0]);
      if (addr_known(int'(a))) check8("dataIn", dataIn, exp_read(int'(a)));
    end
    model_step(int'(a), d, we, rdy, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [7:0] a, input logic [7:0] exp, input string tag);
    dataAddr    = a;
    writeEnable = 1'b0;
    #1;
    check8(tag, dataIn, exp);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    tick(8'h00, 8'h00, 0, 0, 1, 0);
    tick(8'h00, 8'h00, 0, 0, 1, 0);

    // Reset state
    peek(8'hF1, 8'h02, "rst_status");
    check8("rst_txvalid", {7'b0, tx_valid}, 8'h00);
    peek(8'hF0, 8'h00, "rst_txdata_rd");

    // RAM write then same-cycle read; TXDATA write leaves RAM alone
    tick(8'h10, 8'h5A, 1, 0, 0, 1);
    peek(8'h10, 8'h5A, "ram_rd");
    tick(8'hF0, 8'h5A, 1, 0, 0, 1);
    peek(8'h10, 8'h5A, "ram_untouched");
    tick(8'h00, 8'h00, 0, 1, 0, 1);

    // Fill, overflow, drain in order
    for (int i = 1; i <= 4; i++) tick(8'hF0, 8'(i), 1, 0, 0, 1);
    peek(8'hF1, 8'h01, "full_status");
    tick(8'hF0, 8'h05, 1, 0, 0, 1);
    peek(8'hF1, 8'h09, "ovf_status");
    for (int i = 1; i <= 4; i++) begin
      check8("drain_order", tx_data, 8'(i));
      tick(8'h00, 8'h00, 0, 1, 0, 1);
    end
    check8("drain_empty", {7'b0, tx_valid}, 8'h00);
    tick(8'hF1, 8'h08, 1, 0, 0, 1);
    peek(8'hF1, 8'h02, "ovf_clr");

    // Push + pop same cycle with two entries
    tick(8'hF0, 8'hA1, 1, 0, 0, 1);
    tick(8'hF0, 8'hA2, 1, 0, 0, 1);
    tick(8'hF0, 8'h77, 1, 1, 0, 1);
    peek(8'hF1, 8'h00, "pushpop_status");
    check8("pushpop_head", tx_data, 8'hA2);
    tick(8'h00, 8'h00, 0, 1, 0, 1);
    check8("pushpop_last", tx_data, 8'h77);
    tick(8'h00, 8'h00, 0, 1, 0, 1);

    // Full FIFO with same-cycle push + pop: push dropped, ovf set
    for (int i = 0; i < 4; i++) tick(8'hF0, 8'hC0 + 8'(i), 1, 0, 0, 1);
    tick(8'hF0, 8'hEE, 1, 1, 0, 1);
    peek(8'hF1, 8'h08, "full_pushpop_ovf");
    tick(8'hF1, 8'h08, 1, 0, 0, 1);
    peek(8'hF1, 8'h00, "full_pushpop_clr");

    // Counter snapshot: reset, five idle cycles, snapshot on the sixth
    tick(8'h00, 8'h00, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) tick(8'h00, 8'h00, 0, 0, 0, 1);
    tick(8'hF4, 8'h00, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) tick(8'hF5, 8'h00, 0, 0, 0, 1);
`ifdef DMEM_CYCLE_CNT_EN
    peek(8'hF4, 8'h05, "cnt_lo");
`else
    peek(8'hF4, 8'h00, "cnt_lo");
`endif
    peek(8'hF5, 8'h00, "cnt_hi");

    // Reset mid-drain, unmapped address
    for (int i = 0; i < 3; i++) tick(8'hF0, 8'h30 + 8'(i), 1, 0, 0, 1);
    tick(8'h00, 8'h00, 0, 1, 0, 1);
    tick(8'h00, 8'h00, 0, 1, 1, 1);
    check8("rst_mid_txvalid", {7'b0, tx_valid}, 8'h00);
    peek(8'hF1, 8'h02, "rst_mid_status");
    tick(8'hF8, 8'h33, 1, 0, 0, 1);
    peek(8'hF8, 8'h00, "unmapped");

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int sel;
      logic [7:0] a;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3: a = 8'($urandom_range(0, 31));
        4, 5:       a = 8'hF0;
        6:          a = 8'hF1;
        7:          a = 8'hF4;
        8:          a = 8'hF5;
        default:    a = 8'($urandom_range(0, 255));
      endcase
      tick(a, 8'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           $urandom_range(0, 299) == 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
